// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory address, picks the next PC
// from the instruction sitting in ID (one architectural delay slot), and
// registers the fetched word together with its PC and fetch-error flag.
module if_id_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic [1:0]  id_npc_op,
    input  logic        id_branch_taken,
    input  logic [31:0] id_imm32,
    input  logic [31:0] id_rs_data,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        id_adel
);

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    logic [31:0]        pc_p0;
    logic [31:0]        pc4_p0;
    logic [31:0]        npc_p0;
    logic signed [31:0] br_off_p0;
    logic               adel_p0;

    // Fetch address is misaligned or outside the legal instruction window.
    function automatic logic fetch_addr_err(input logic [31:0] addr);
        fetch_addr_err = (addr[1:0] != 2'b00) || (addr < PC_LO) || (addr > PC_HI);
    endfunction

    assign im_addr = pc_p0;
    assign id_pc8  = id_pc + 32'd8;
    assign adel_p0 = fetch_addr_err(pc_p0);

    // Next-PC select: redirect only when the ID slot holds a real instruction.
    always_comb begin
        pc4_p0    = pc_p0 + 32'd4;
        br_off_p0 = $signed(id_imm32) <<< 2;
        npc_p0    = pc4_p0;
        if (id_valid) begin
            case (id_npc_op)
                NPC_BRANCH: if (id_branch_taken)
                                npc_p0 = id_pc + 32'd4 + $unsigned(br_off_p0);
                NPC_JUMP:   npc_p0 = {id_pc[31:28], id_instr[25:0], 2'b00};
                NPC_JR:     npc_p0 = id_rs_data;
                default:    npc_p0 = pc4_p0;
            endcase
        end
    end

    // ---- IF -> ID boundary ----
    // PC and IF/ID register update with priority reset > flush > stall > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0    <= PC_RESET;
            id_instr <= INSTR_NOP;
            id_pc    <= 32'd0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (flush) begin
            if (!stall) begin
                pc_p0 <= npc_p0;
            end
            id_instr <= INSTR_NOP;
            id_pc    <= pc_p0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (!stall) begin
            pc_p0    <= npc_p0;
            id_instr <= adel_p0 ? INSTR_NOP : im_rdata;
            id_pc    <= pc_p0;
            id_valid <= 1'b1;
            id_adel  <= adel_p0;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed walk through the fetch/redirect cases
// followed by randomized cycles compared against a behavioural model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [1:0]  id_npc_op;
    logic        id_branch_taken;
    logic [31:0] id_imm32;
    logic [31:0] id_rs_data;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
    logic        id_adel;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_idpc;
    logic        m_valid, m_adel;

    logic [31:0] frozen_pc, frozen_instr;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .im_addr         (im_addr),
        .im_rdata        (im_rdata),
        .id_npc_op       (id_npc_op),
        .id_branch_taken (id_branch_taken),
        .id_imm32        (id_imm32),
        .id_rs_data      (id_rs_data),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc8          (id_pc8),
        .id_valid        (id_valid),
        .id_adel         (id_adel)
    );

    // Instruction memory contents: a jal with index 0xC10 lives at 0x3020.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_3020) return {6'h03, 26'h000_0C10};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign im_rdata = imem(im_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model of one clock edge.
    task automatic model_edge(input logic rst, input logic st, input logic fl,
                              input logic [1:0] op, input logic tk,
                              input logic [31:0] imm, input logic [31:0] rs);
        logic [31:0] nxt, old_pc;
        logic        err;
        if (rst) begin
            m_pc = 32'h3000; m_instr = 0; m_idpc = 0; m_valid = 0; m_adel = 0;
            return;
        end
        old_pc = m_pc;
        nxt = old_pc + 4;
        if (m_valid) begin
            if (op == 1 && tk) nxt = m_idpc + 4 + imm * 4;
            if (op == 2)       nxt = {m_idpc[31:28], m_instr[25:0], 2'b00};
            if (op == 3)       nxt = rs;
        end
        err = (old_pc % 4 != 0) || (old_pc < 32'h3000) || (old_pc > 32'h6FFC);
        if (fl) begin
            m_instr = 0; m_valid = 0; m_adel = 0; m_idpc = old_pc;
            if (!st) m_pc = nxt;
        end else if (!st) begin
            m_instr = err ? 32'h0 : imem(old_pc);
            m_idpc  = old_pc;
            m_valid = 1;
            m_adel  = err;
            m_pc    = nxt;
        end
    endtask

    // Drive one cycle, update the model on the edge, then compare all outputs.
    task automatic cyc(input logic rst, input logic st, input logic fl,
                       input logic [1:0] op, input logic tk,
                       input logic [31:0] imm, input logic [31:0] rs);
        reset = rst; stall = st; flush = fl; id_npc_op = op;
        id_branch_taken = tk; id_imm32 = imm; id_rs_data = rs;
        @(posedge clk);
        model_edge(rst, st, fl, op, tk, imm, rs);
        #1;
        chk("im_addr",  im_addr,  m_pc);
        chk("id_instr", id_instr, m_instr);
        chk("id_pc",    id_pc,    m_idpc);
        chk("id_pc8",   id_pc8,   m_idpc + 32'd8);
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        chk("id_adel",  {31'd0, id_adel},  {31'd0, m_adel});
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    endtask

    task automatic restart(input int n);
        cyc(1, 0, 0, 2'd0, 0, 32'd0, 32'd0);
        seq(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; stall = 0; flush = 0; id_npc_op = 0;
        id_branch_taken = 0; id_imm32 = 0; id_rs_data = 0;
        m_pc = 0; m_instr = 0; m_idpc = 0; m_valid = 0; m_adel = 0;

        // reset state and sequential fetch
        cyc(1, 0, 0, 2'd0, 0, 32'd0, 32'd0);
        chk("rst_addr",  im_addr, 32'h3000);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc8",   id_pc8, 32'd8);
        chk("rst_adel",  {31'd0, id_adel}, 32'd0);
        seq(1);
        chk("seq1_addr", im_addr, 32'h3004);
        chk("seq1_idpc", id_pc, 32'h3000);
        chk("seq1_vld",  {31'd0, id_valid}, 32'd1);
        seq(2);
        chk("seq3_addr", im_addr, 32'h300C);
        chk("seq3_idpc", id_pc, 32'h3008);

        // beq taken at id_pc 0x3010
        restart(5);
        chk("beq_idpc", id_pc, 32'h3010);
        cyc(0, 0, 0, 2'd1, 1, 32'hFFFF_FFFC, 32'd0);
        chk("beq_t_addr", im_addr, 32'h3004);
        chk("beq_t_slot", id_pc, 32'h3014);
        // beq not taken
        restart(5);
        cyc(0, 0, 0, 2'd1, 0, 32'hFFFF_FFFC, 32'd0);
        chk("beq_nt_addr", im_addr, 32'h3018);

        // jal at id_pc 0x3020
        restart(9);
        chk("jal_idpc", id_pc, 32'h3020);
        chk("jal_pc8",  id_pc8, 32'h3028);
        cyc(0, 0, 0, 2'd2, 0, 32'd0, 32'd0);
        chk("jal_addr", im_addr, 32'h3040);

        // jr held off by a 3-cycle stall
        restart(2);
        frozen_pc = im_addr; frozen_instr = id_instr;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 2'd3, 0, 32'd0, 32'h3100);
            chk("stall_addr",  im_addr, frozen_pc);
            chk("stall_instr", id_instr, frozen_instr);
        end
        cyc(0, 0, 0, 2'd3, 0, 32'd0, 32'h3100);
        chk("jr_addr",  im_addr, 32'h3100);
        chk("jr_slot",  id_instr, imem(frozen_pc));
        chk("jr_slotpc", id_pc, frozen_pc);

        // reset in the middle of a stalled jr
        restart(2);
        cyc(0, 1, 0, 2'd3, 0, 32'd0, 32'h3100);
        cyc(0, 1, 0, 2'd3, 0, 32'd0, 32'h3100);
        cyc(1, 1, 1, 2'd3, 0, 32'd0, 32'h3100);
        chk("rst_mid_addr", im_addr, 32'h3000);
        cyc(0, 0, 0, 2'd3, 0, 32'd0, 32'h3100);
        chk("rst_mid_next", im_addr, 32'h3004);

        // flush with and without stall
        restart(2);
        cyc(0, 1, 1, 2'd0, 0, 32'd0, 32'd0);
        chk("fs_addr",  im_addr, 32'h3008);
        chk("fs_valid", {31'd0, id_valid}, 32'd0);
        chk("fs_instr", id_instr, 32'd0);
        cyc(0, 0, 1, 2'd0, 0, 32'd0, 32'd0);
        chk("f_addr",  im_addr, 32'h300C);
        chk("f_valid", {31'd0, id_valid}, 32'd0);

        // fetch address errors: misaligned, then beyond PC_HI
        restart(2);
        cyc(0, 0, 0, 2'd3, 0, 32'd0, 32'h3002);
        chk("mis_addr", im_addr, 32'h3002);
        seq(1);
        chk("mis_adel",  {31'd0, id_adel}, 32'd1);
        chk("mis_instr", id_instr, 32'd0);
        chk("mis_valid", {31'd0, id_valid}, 32'd1);
        chk("mis_next",  im_addr, 32'h3006);
        cyc(0, 0, 0, 2'd3, 0, 32'd0, 32'h7000);
        chk("hi_addr", im_addr, 32'h7000);
        seq(1);
        chk("hi_adel",  {31'd0, id_adel}, 32'd1);
        chk("hi_instr", id_instr, 32'd0);
        chk("hi_valid", {31'd0, id_valid}, 32'd1);
        chk("hi_idpc",  id_pc, 32'h7000);

        // randomized traffic against the model
        restart(1);
        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_st, r_fl, r_tk;
            logic [1:0]  r_op;
            logic [31:0] r_imm, r_rs;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 20);
            r_fl  = ($urandom_range(0, 99) < 10);
            r_tk  = $urandom_range(0, 1);
            r_op  = 2'($urandom_range(0, 3));
            r_imm = 32'($signed($urandom_range(0, 63)) - 32);
            if ($urandom_range(0, 9) == 0) r_rs = $urandom;
            else r_rs = 32'h3000 + 4 * $urandom_range(0, 4095);
            cyc(r_rst, r_st, r_fl, r_op, r_tk, r_imm, r_rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
